// File: rtl/aes_pkg.sv
// Shared AES types, the AES-128 round count, the round-constant table and GF(2^8) helpers.
// Used by the key-schedule RTL and by its bench.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key128_t;

    localparam int AES_NR128 = 10;

    // Round constant for round r sits at index r, already aligned as {rc, 24'h0}
    localparam word_t AES_RCON [1:AES_NR128] = '{
        32'h0100_0000, 32'h0200_0000, 32'h0400_0000, 32'h0800_0000, 32'h1000_0000,
        32'h2000_0000, 32'h4000_0000, 32'h8000_0000, 32'h1b00_0000, 32'h3600_0000
    };

    typedef enum logic [1:0] {
        KX_IDLE,
        KX_EXPAND,
        KX_DONE
    } kexp_state_t;

    // Shift-and-add multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_kexp_subword.sv
// SubWord(RotWord(w)) for the key schedule; purely combinational.
module aes_kexp_subword (
    input  logic [31:0] w,
    output logic [31:0] t
);

    logic [31:0] rot;

    assign rot = {w[23:0], w[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .s (t[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] inv;
    logic [7:0] pw;

    // a^254 is the inverse (and maps 0 to 0): multiply a^2, a^4, ..., a^128 together
    always_comb begin
        // NOTE: every combinational variable is assigned before any use so no latch is inferred
        inv = 8'h01;
        pw  = a;
        for (int i = 0; i < 7; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
    end

    assign s = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/aes_key_expand_128.sv
// AES-128 key schedule stage: loads a cipher key on kld and emits one round key per cycle.
// Optional round-key register file built when AES_KEXP_RK_STORE_EN is defined.
module aes_key_expand_128
    import aes_pkg::*;
#(
    parameter int NR = AES_NR128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic [31:0]  rcon,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3,
    output logic [3:0]   round,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
`ifdef AES_KEXP_RK_STORE_EN
    ,
    input  logic [3:0]   rk_raddr,
    output logic [127:0] rk_rdata
`endif
);

    localparam int RW = $clog2(NR + 1);

    kexp_state_t   state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    key128_t       key_q, key_d;
    logic          valid_q, valid_d;
    word_t         sub_w, t_w, n0, n1, n2, n3;

    assign {wo_0, wo_1, wo_2, wo_3} = key_q;
    assign round    = 4'(round_q);
    assign rk_valid = valid_q;
    assign busy     = (state_q == KX_EXPAND);
    assign done     = (state_q == KX_DONE);

    aes_kexp_subword u_subword (
        .w (key_q[31:0]),
        .t (sub_w)
    );

    assign t_w = sub_w ^ rcon;
    assign n0  = key_q[127:96] ^ t_w;
    assign n1  = n0 ^ key_q[95:64];
    assign n2  = n1 ^ key_q[63:32];
    assign n3  = n2 ^ key_q[31:0];

    // kld wins over expansion in every state, including the cycle that would finish
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        key_d   = key_q;
        valid_d = 1'b0;
        if (kld) begin
            state_d = KX_EXPAND;
            round_d = '0;
            key_d   = key;
            valid_d = 1'b1;
        end else if (state_q == KX_EXPAND) begin
            key_d   = {n0, n1, n2, n3};
            round_d = round_q + 1'b1;
            valid_d = 1'b1;
            if (round_q == RW'(NR - 1)) state_d = KX_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= KX_IDLE;
            round_q <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values
            state_q <= state_d;
            round_q <= round_d;
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

`ifdef AES_KEXP_RK_STORE_EN
    key128_t rk_mem [NR+1];

    // The key shown during an rk_valid cycle lands in its slot at the closing edge,
    // so a same-cycle read of that slot still returns the previous contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the store is small and must read 0 after reset, so every entry is cleared
            for (int i = 0; i <= NR; i++) rk_mem[i] <= '0;
        end else if (valid_q) begin
            rk_mem[round_q] <= key_q;
        end
    end

    assign rk_rdata = (rk_raddr <= 4'(NR)) ? rk_mem[rk_raddr] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench for aes_key_expand_128: FIPS-197 schedule model, directed cases, random loads/resets.
// Exercises the round-key store when AES_KEXP_RK_STORE_EN is defined.
module tb_aes_key_expand_128;
    import aes_pkg::*;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam key128_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam key128_t FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam key128_t FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam key128_t ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam key128_t ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic         kld  = 1'b0;
    logic [127:0] key  = '0;
    logic [31:0]  rcon = '0;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;
    logic [3:0]   round;
    logic         rk_valid, busy, done;
`ifdef AES_KEXP_RK_STORE_EN
    logic [3:0]   rk_raddr = '0;
    logic [127:0] rk_rdata;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_key_expand_128 dut (
        .clk      (clk),
        .rst      (rst),
        .kld      (kld),
        .key      (key),
        .rcon     (rcon),
        .wo_0     (wo_0),
        .wo_1     (wo_1),
        .wo_2     (wo_2),
        .wo_3     (wo_3),
        .round    (round),
        .rk_valid (rk_valid),
        .busy     (busy),
        .done     (done)
`ifdef AES_KEXP_RK_STORE_EN
        ,
        .rk_raddr (rk_raddr),
        .rk_rdata (rk_rdata)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // FIPS-197 key expansion, written directly from the word recurrence
    function automatic word_t sub_rot(input word_t w);
        word_t r;
        r = {w[23:0], w[31:24]};
        return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
    endfunction

    function automatic key128_t round_key(input key128_t k, input int r);
        word_t w [0:4*AES_NR128+3];
        word_t t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 4*(r+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_rot(t) ^ AES_RCON[i/4];
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Model state: the loaded cipher key and the index of the round on display
    key128_t m_key    = '0;
    int      m_round  = 0;
    logic    m_valid  = 1'b0;
    logic    m_busy   = 1'b0;
    logic    m_done   = 1'b0;
    key128_t m_store [0:AES_NR128];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_key   <= '0;
            m_round <= 0;
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            for (int i = 0; i <= AES_NR128; i++) m_store[i] <= '0;
        end else begin
            if (m_valid) m_store[m_round] <= round_key(m_key, m_round);
            if (kld) begin
                m_key   <= key;
                m_round <= 0;
                m_valid <= 1'b1;
                m_busy  <= 1'b1;
                m_done  <= 1'b0;
            end else if (m_busy) begin
                m_round <= m_round + 1;
                m_valid <= 1'b1;
                if (m_round + 1 == AES_NR128) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("wo", {wo_0, wo_1, wo_2, wo_3}, round_key(m_key, m_round));
        check("round", 128'(round), 128'(m_round));
        check("rk_valid", 128'(rk_valid), 128'(m_valid));
        check("busy", 128'(busy), 128'(m_busy));
        check("done", 128'(done), 128'(m_done));
`ifdef AES_KEXP_RK_STORE_EN
        check("rk_rdata", rk_rdata, (rk_raddr <= 4'(AES_NR128)) ? m_store[rk_raddr] : '0);
`endif
    end

    // Inputs change 2 time units after the falling edge; rcon follows the upstream generator while busy
    task automatic drive(input logic k, input key128_t kv);
        @(negedge clk);
        #2;
        kld  = k;
        key  = kv;
        rcon = m_busy ? AES_RCON[m_round + 1] : $urandom;
`ifdef AES_KEXP_RK_STORE_EN
        rk_raddr = 4'($urandom_range(0, 15));
`endif
    endtask

    function automatic key128_t rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        check("model_fips_r1", round_key(FIPS_KEY, 1), FIPS_R1);
        check("model_zero_r10", round_key('0, 10), ZERO_R10);

        repeat (2) @(negedge clk);
        #1;
        check("reset_wo", {wo_0, wo_1, wo_2, wo_3}, '0);
        check("reset_flags", 128'({round, rk_valid, busy, done}), '0);
        #1;
        rst = 1'b1;

        // FIPS-197 A.1 run with a single-cycle kld
        drive(1'b1, FIPS_KEY);
        drive(1'b0, '0);
        check("fips_r0", {wo_0, wo_1, wo_2, wo_3}, FIPS_KEY);
        drive(1'b0, '0);
        check("fips_r1", {wo_0, wo_1, wo_2, wo_3}, FIPS_R1);
        repeat (8) drive(1'b0, '0);
        check("fips_not_done_r9", 128'(done), '0);
        drive(1'b0, '0);
        check("fips_r10", {wo_0, wo_1, wo_2, wo_3}, FIPS_R10);
        check("fips_done", 128'({round, busy, done}), 128'({4'd10, 1'b0, 1'b1}));
        drive(1'b0, '0);
        check("fips_hold", {wo_0, wo_1, wo_2, wo_3}, FIPS_R10);
        check("fips_hold_valid", 128'(rk_valid), '0);
`ifdef AES_KEXP_RK_STORE_EN
        rk_raddr = 4'd10;
        #1;
        check("store_r10", rk_rdata, FIPS_R10);
        rk_raddr = 4'd0;
        #1;
        check("store_r0", rk_rdata, FIPS_KEY);
        rk_raddr = 4'd15;
        #1;
        check("store_oob", rk_rdata, '0);
`endif

        // Reload with the all-zero key in the middle of a run
        drive(1'b1, FIPS_KEY);
        repeat (6) drive(1'b0, '0);
        check("mid_round5", 128'(round), 128'd5);
        drive(1'b1, '0);
        drive(1'b0, '0);
        check("reload_r0", 128'({round, rk_valid}), 128'({4'd0, 1'b1}));
        drive(1'b0, '0);
        check("zero_r1", {wo_0, wo_1, wo_2, wo_3}, ZERO_R1);
        repeat (9) drive(1'b0, '0);
        check("zero_r10", {wo_0, wo_1, wo_2, wo_3}, ZERO_R10);

        // Asynchronous reset at round 3
        drive(1'b1, rand_key());
        repeat (4) drive(1'b0, '0);
        check("pre_reset_round3", 128'(round), 128'd3);
        rst = 1'b0;
        #1;
        check("async_rst_wo", {wo_0, wo_1, wo_2, wo_3}, '0);
        check("async_rst_flags", 128'({round, rk_valid, busy, done}), '0);
        drive(1'b0, '0);
        drive(1'b0, '0);
        rst = 1'b1;
        repeat (3) drive(1'b0, '0);
        check("idle_after_rst", 128'({round, rk_valid, busy}), '0);

        // kld held for three edges
        repeat (3) drive(1'b1, FIPS_KEY);
        check("held_kld_r0", 128'({round, rk_valid, busy}), 128'({4'd0, 1'b1, 1'b1}));
        repeat (10) drive(1'b0, '0);
        check("held_not_done", 128'(done), '0);
        drive(1'b0, '0);
        check("held_done", 128'({round, done}), 128'({4'd10, 1'b1}));
        check("held_r10", {wo_0, wo_1, wo_2, wo_3}, FIPS_R10);

        // Random loads, keys and reset pulses
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 11) == 0), rand_key());
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b0;
                drive(1'b0, '0);
                rst = 1'b1;
            end
        end
        drive(1'b0, '0);
        drive(1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
